irq_ctrl: RTL
=============

# irq_ctrl

Interrupt controller for the TRSQ8 core. It collects up to eight peripheral interrupt sources, latches them as pending, applies a software mask and fixed priority, and drives the core's single `irq_ip` line. The core services an interrupt through an acknowledge/EOI handshake on the 8-bit peripheral bus. The block sits on the peripheral bus beside the other memory-mapped peripherals.

## Interface
- `N_SRC`, default 8: number of interrupt sources, 1..8.
- `BASE_ADDR`, default 8'hF0: bus address of register offset 0; five consecutive addresses are decoded.
- `clk_ip`  in  1  single clock; all logic rises on posedge.
- `reset_ip`  in  1  synchronous, active-high reset.
- `src_ip`  in  N_SRC  interrupt sources, synchronous to `clk_ip`; bit 0 has the highest priority.
- `addr_ip`  in  8  peripheral bus address.
- `wdata_ip`  in  8  peripheral bus write data.
- `we_ip`  in  1  write strobe, one cycle per access.
- `re_ip`  in  1  read strobe, one cycle per access; qualifies read side effects only.
- `rdata_op`  out  8  read data, combinational from `addr_ip`; 8'h00 when the address is not decoded.
- `irq_op`  out  1  registered interrupt request to the core.

## Operation
- Registers at `BASE_ADDR` plus offset:
  - +0 PEND: R/W1C pending bits.
  - +1 MASK: R/W enable bits; 1 = enabled.
  - +2 VEC: read-only. Returns `{5'b0, cur_id}` in REQ and SERV states, 8'hFF in IDLE.
  - +3 EOI: write-only; any value ends service.
  - +4 EDGE: R/W trigger mode per source; 1 = edge-triggered.
- Bits at or above `N_SRC` read as 0 and ignore writes.
- `src_r` is `src_ip` registered once.
- Level-mode source: PEND[i] = `src_r[i]` every cycle; W1C has no effect.
- Edge-mode source: PEND[i] sets on `src_r[i] & ~src_prev[i]` and clears on W1C.
  - If set and clear happen in the same cycle, set wins.
- `act = PEND & MASK`. `cur_id` is the index of the lowest set bit of `act`.
- FSM, states IDLE / REQ / SERV:
  - IDLE -> REQ when `act != 0`; `cur_id` is latched.
  - REQ: `cur_id` is re-evaluated every cycle, so a higher-priority arrival preempts before acknowledge.
  - REQ -> IDLE when `act == 0` (source withdrew or was masked).
  - REQ -> SERV on `re_ip` with VEC address. At the same edge, the edge-mode PEND[`cur_id`] is cleared. `cur_id` is frozen from then on.
  - SERV -> IDLE on `we_ip` with EOI address.
  - EOI in IDLE or REQ is ignored. A VEC read in IDLE or SERV has no side effect.
- `irq_op` = 1 exactly when the state is REQ. There is no nesting.
- Reset sets PEND, MASK, EDGE, `src_r`, `src_prev` and `cur_id` to 0, the state to IDLE and `irq_op` to 0. Reset during SERV abandons service with no EOI required.

## Timing
- A source rising at cycle t is seen in `src_r` at t+1, PEND at t+2, `irq_op` at t+3.
- `irq_op` deasserts on the cycle after the acknowledging VEC read.
- After EOI, a still-pending source re-raises `irq_op` 2 cycles after the EOI write edge.
- A MASK write takes effect on `act` in the cycle after the write.
- `rdata_op` reflects register state before the current edge; a read-with-clear returns the pre-clear value.

## Configuration
- `IRQ_CTRL_EDGE_EN` defined: edge detection and the EDGE register are built as described above.
- `IRQ_CTRL_EDGE_EN` undefined:
  - All sources are level-triggered.
  - The EDGE register reads 8'h00 and ignores writes.
  - `src_prev` is not instantiated.
  - W1C on PEND has no effect.

## Structure
- `irq_ctrl_pkg` holds:
  - register offset constants `IRQ_OFS_PEND`..`IRQ_OFS_EDGE`;
  - the FSM state encoding `IRQ_ST_IDLE`/`IRQ_ST_REQ`/`IRQ_ST_SERV`;
  - `IRQ_VEC_NONE` = 8'hFF.
- Sub-module `irq_prio_enc`: N_SRC-bit fixed-priority encoder with outputs `any_op` and `id_op[2:0]`.

## Test plan
- MASK=8'h04, EDGE=0, `src_ip`=8'h04 held high → `irq_op`=1 three cycles later; VEC reads 8'h02; `irq_op`=0 on the next cycle; after EOI it re-asserts 2 cycles later because the level is still high.
- MASK=8'hFF, EDGE=8'hFF, pulse bits 5 and 1 in the same cycle → VEC=8'h01. After EOI, `irq_op` re-asserts and VEC=8'h05. PEND reads 8'h00 after the second acknowledge.
- In REQ with `cur_id`=3, bit 0 rises → VEC reads 8'h00. Bit 3 stays pending (PEND=8'h08 in edge mode).
- MASK=8'h00 with source active → `irq_op` stays 0 and PEND shows the bit. Writing MASK to enable it raises `irq_op` 2 cycles after the write.
- Edge mode: a W1C to PEND bit 2 in the same cycle as a new rising edge on bit 2 → PEND[2]=1. A VEC read in IDLE returns 8'hFF.
- Assert `reset_ip` during SERV → the next cycle has state IDLE, `irq_op`=0, PEND/MASK/EDGE=0. A following EOI write is ignored.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register offsets, FSM encoding and constants for irq_ctrl
package irq_ctrl_pkg;
    localparam logic [7:0] IRQ_OFS_PEND = 8'd0;
    localparam logic [7:0] IRQ_OFS_MASK = 8'd1;
    localparam logic [7:0] IRQ_OFS_VEC  = 8'd2;
    localparam logic [7:0] IRQ_OFS_EOI  = 8'd3;
    localparam logic [7:0] IRQ_OFS_EDGE = 8'd4;
    localparam logic [7:0] IRQ_VEC_NONE = 8'hFF;
    typedef enum logic [1:0] {IRQ_ST_IDLE, IRQ_ST_REQ, IRQ_ST_SERV} irq_st_e;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: fixed-priority encoder, bit 0 wins
module irq_prio_enc #(
    parameter int N_SRC = 8
) (
    input  logic [N_SRC-1:0] req_ip,
    output logic             any_op,
    output logic [2:0]       id_op
);
    // scan from the top down so the lowest set bit is the last to land
    always_comb begin
        id_op = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (req_ip[i]) id_op = 3'(i);
        any_op = |req_ip;
    end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: 8-source interrupt controller with mask, priority and ack/EOI; edge mode under IRQ_CTRL_EDGE_EN
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int         N_SRC     = 8,
    parameter logic [7:0] BASE_ADDR = 8'hF0
) (
    input  logic             clk_ip,
    input  logic             reset_ip,
    input  logic [N_SRC-1:0] src_ip,
    input  logic [7:0]       addr_ip,
    input  logic [7:0]       wdata_ip,
    input  logic             we_ip,
    input  logic             re_ip,
    output logic [7:0]       rdata_op,
    output logic             irq_op
);
    localparam logic [7:0] VM = 8'((16'd1 << N_SRC) - 16'd1);

    logic [7:0] src_x, src_r, pend, pend_nxt, mask, edge_mode, act;
    logic [2:0] cur_id, enc_id;
    logic       enc_any, ack, eoi;
    logic       sel_pend, sel_mask, sel_vec, sel_eoi, sel_edge;
    irq_st_e    state, state_nxt;

    assign sel_pend = addr_ip == 8'(BASE_ADDR + IRQ_OFS_PEND);
    assign sel_mask = addr_ip == 8'(BASE_ADDR + IRQ_OFS_MASK);
    assign sel_vec  = addr_ip == 8'(BASE_ADDR + IRQ_OFS_VEC);
    assign sel_eoi  = addr_ip == 8'(BASE_ADDR + IRQ_OFS_EOI);
    assign sel_edge = addr_ip == 8'(BASE_ADDR + IRQ_OFS_EDGE);
    assign ack      = state == IRQ_ST_REQ && re_ip && sel_vec;
    assign eoi      = state == IRQ_ST_SERV && we_ip && sel_eoi;
    assign act      = pend & mask;

    // widen sources to the 8-bit register width, unused bits zero
    always_comb begin
        src_x = 8'h00;
        src_x[N_SRC-1:0] = src_ip;
    end

    irq_prio_enc #(.N_SRC(N_SRC)) u_enc (
        .req_ip (act[N_SRC-1:0]),
        .any_op (enc_any),
        .id_op  (enc_id)
    );

`ifdef IRQ_CTRL_EDGE_EN
    logic [7:0] src_prev, clr;

    // previous synchronised source sample for rising-edge detection
    always_ff @(posedge clk_ip)
        src_prev <= reset_ip ? 8'h00 : src_r;

    // per-source trigger mode register
    always_ff @(posedge clk_ip)
        edge_mode <= reset_ip ? 8'h00 : (we_ip && sel_edge) ? wdata_ip & VM : edge_mode;

    assign clr      = ((we_ip && sel_pend) ? wdata_ip : 8'h00) | (ack ? 8'h01 << cur_id : 8'h00);
    assign pend_nxt = (edge_mode & ((pend & ~clr) | (src_r & ~src_prev))) | (~edge_mode & src_r);
`else
    assign edge_mode = 8'h00;
    assign pend_nxt  = src_r;
`endif

    // source sync stage, pending and mask registers
    always_ff @(posedge clk_ip) begin
        src_r <= reset_ip ? 8'h00 : src_x;
        pend  <= reset_ip ? 8'h00 : pend_nxt & VM;
        mask  <= reset_ip ? 8'h00 : (we_ip && sel_mask) ? wdata_ip & VM : mask;
    end

    // FSM state register, registered request and vector id tracking until acknowledge
    always_ff @(posedge clk_ip) begin
        if (reset_ip) begin
            state  <= IRQ_ST_IDLE;
            irq_op <= 1'b0;
            cur_id <= 3'd0;
        end else begin
            state  <= state_nxt;
            irq_op <= state_nxt == IRQ_ST_REQ;
            cur_id <= (state != IRQ_ST_SERV && !ack && enc_any) ? enc_id : cur_id;
        end
    end

    // next state: request on any active source, acknowledge via VEC read, end via EOI
    always_comb begin
        state_nxt = state;
        state_nxt = (state == IRQ_ST_IDLE) ? (enc_any ? IRQ_ST_REQ : IRQ_ST_IDLE) :
                    (state == IRQ_ST_REQ)  ? (ack ? IRQ_ST_SERV : enc_any ? IRQ_ST_REQ : IRQ_ST_IDLE) :
                    (eoi ? IRQ_ST_IDLE : IRQ_ST_SERV);
    end

    // combinational read mux, reflects state before the current edge
    always_comb begin
        rdata_op = 8'h00;
        rdata_op = sel_pend ? pend :
                   sel_mask ? mask :
                   sel_vec  ? ((state == IRQ_ST_IDLE) ? IRQ_VEC_NONE : {5'b0, cur_id}) :
                   sel_edge ? edge_mode : 8'h00;
    end
endmodule
